channel_msg_streamer: RTL and testbench
=======================================

CHANNEL_MSG_STREAMER -- requirements
Module: channel_msg_streamer

Interface
REQ-001 SHALL have parameter N, default 204, meaning codeword length in symbols.
REQ-002 SHALL have parameter QUAN_SIZE, default 4, meaning bits per channel message.
REQ-003 SHALL have parameter LANE_NUM, default 17, meaning symbols per output beat; N SHALL be a multiple of LANE_NUM, BEATS = N/LANE_NUM (default 12), AW = max(1, clog2(BEATS)).
REQ-004 SHALL have port sys_clk  input  1  sole clock, all state on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port coded_block  input  N*QUAN_SIZE  received block from the upstream generator; symbol s occupies bits [(s+1)*QUAN_SIZE-1 : s*QUAN_SIZE].
REQ-007 SHALL have port tvalid_in  input  1  single-cycle frame-valid pulse from upstream.
REQ-008 SHALL have port ready_out  output  1  to upstream ready_slave; high when a buffer slot is free.
REQ-009 SHALL have port lane_data  output  LANE_NUM*QUAN_SIZE  current beat to decoder channel memory.
REQ-010 SHALL have port lane_valid  output  1  beat valid.
REQ-011 SHALL have port lane_ready  input  1  decoder accepts beat.
REQ-012 SHALL have port lane_addr  output  AW  beat index 0..BEATS-1 within frame.
REQ-013 SHALL have port lane_last  output  1  high on beat BEATS-1.
REQ-014 SHALL have port frame_cnt  output  16  count of fully emitted frames.
REQ-015 SHALL have port overflow_flag  output  1  sticky dropped-frame indicator.

Function
REQ-016 SHALL hold two frame slots (ping-pong) plus write pointer, read pointer and 2-bit occupancy register (EMPTY=0, ONE=1, FULL=2).
REQ-017 SHALL drive ready_out = (occupancy != FULL), decoded from registers only; no combinational path from lane_ready or tvalid_in.
REQ-018 SHALL capture coded_block into slot[wr_ptr] and toggle wr_ptr on an edge where tvalid_in=1 and ready_out=1.
REQ-019 SHALL, on tvalid_in=1 with ready_out=0, discard the frame, leave slots/pointers unchanged, and set overflow_flag=1 until reset.
REQ-020 SHALL run output FSM IDLE/STREAM: IDLE->STREAM when occupancy!=0; STREAM->IDLE after last-beat handshake if occupancy becomes 0, else stays STREAM with beat index 0 on the next slot.
REQ-021 SHALL assert lane_valid in the first cycle after the capture edge of a frame entering an empty buffer (one-cycle latency).
REQ-022 SHALL drive lane_data = slot[rd_ptr] symbols lane_addr*LANE_NUM .. lane_addr*LANE_NUM+LANE_NUM-1, lane j at bits [(j+1)*QUAN_SIZE-1 : j*QUAN_SIZE].
REQ-023 SHALL advance lane_addr only on lane_valid&&lane_ready; lane_data, lane_addr, lane_last SHALL stay stable while lane_valid=1 and lane_ready=0.
REQ-024 SHALL, on last-beat handshake, reset lane_addr to 0, toggle rd_ptr, decrement occupancy and increment frame_cnt modulo 2^16 (0xFFFF->0x0000).
REQ-025 SHALL, on an edge with both a capture and a last-beat handshake, leave occupancy unchanged and apply both pointer updates.
REQ-026 SHALL emit frames strictly in capture order; back-to-back frames SHALL stream with no idle cycle when lane_ready=1.

Reset
REQ-027 SHALL, while rstn=0, force ready_out=1, lane_valid=0, lane_last=0, lane_addr=0, lane_data=0, frame_cnt=0, overflow_flag=0, occupancy=EMPTY, pointers=0, FSM=IDLE; slot contents need not clear but SHALL not be visible.
REQ-028 SHALL discard any partially emitted or buffered frame on reset mid-operation; first beat after release SHALL come from the next captured frame.

Verification
REQ-029 Reset: rstn=0 for 3 cycles -> all outputs per REQ-027, ready_out=1.
REQ-030 Single frame, symbol s = s mod 16, lane_ready=1 -> 12 consecutive beats, beat k lane j = (17k+j) mod 16, lane_last only at lane_addr=11, frame_cnt=1, lane_valid low after.
REQ-031 Backpressure: lane_ready random 50% -> lane_data/lane_addr unchanged in every valid&&!ready cycle, all 12 beats delivered once in order.
REQ-032 Overflow: lane_ready=0, pulses frames A, B, C -> ready_out=0 after B, C dropped, overflow_flag=1; lane_ready=1 -> A then B emitted, frame_cnt=2.
REQ-033 Simultaneous: frame B pulsed on the edge of A's last-beat handshake -> occupancy stays 1, B beat 0 follows A beat 11 with no gap.
REQ-034 Reset mid-stream at lane_addr=5 -> outputs return to reset values, next frame starts at lane_addr=0, frame_cnt counts from 0.

Source files
------------

// File: rtl/channel_msg_streamer.sv
// Two-slot ping-pong frame buffer that captures whole codewords and streams
// them to the decoder one LANE_NUM-symbol beat at a time under valid/ready.
module channel_msg_streamer #(
    parameter int N         = 204,
    parameter int QUAN_SIZE = 4,
    parameter int LANE_NUM  = 17,
    localparam int BEATS    = N / LANE_NUM,
    localparam int AW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                          sys_clk,
    input  logic                          rstn,
    input  logic [N*QUAN_SIZE-1:0]        coded_block,
    input  logic                          tvalid_in,
    output logic                          ready_out,
    output logic [LANE_NUM*QUAN_SIZE-1:0] lane_data,
    output logic                          lane_valid,
    input  logic                          lane_ready,
    output logic [AW-1:0]                 lane_addr,
    output logic                          lane_last,
    output logic [15:0]                   frame_cnt,
    output logic                          overflow_flag
);

    localparam int W  = N * QUAN_SIZE;
    localparam int LW = LANE_NUM * QUAN_SIZE;
    localparam logic [1:0]    OCC_EMPTY = 2'd0;
    localparam logic [1:0]    OCC_FULL  = 2'd2;
    localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   slot0_q, slot0_d, slot1_q, slot1_d;
    logic           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]     occ_q, occ_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           ovf_q, ovf_d;

    logic           capture_s, handshake_s, last_hs_s;
    logic [W-1:0]   rd_slot_s;
    logic [LW-1:0]  beats_s [BEATS];

    // Handshake qualifiers derived from registered state only
    always_comb begin
        ready_out   = (occ_q != OCC_FULL);
        lane_valid  = (state_q == ST_STREAM);
        capture_s   = tvalid_in && ready_out;
        handshake_s = lane_valid && lane_ready;
        last_hs_s   = handshake_s && (addr_q == LAST_BEAT);
    end

    // Next-state for buffer bookkeeping and output FSM
    always_comb begin
        state_d     = state_q;
        slot0_d     = slot0_q;
        slot1_d     = slot1_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        addr_d      = addr_q;
        frame_cnt_d = frame_cnt_q;
        ovf_d       = ovf_q;

        if (capture_s) begin
            if (wr_ptr_q) begin
                slot1_d = coded_block;
            end else begin
                slot0_d = coded_block;
            end
            wr_ptr_d = ~wr_ptr_q;
        end else if (tvalid_in) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        if (last_hs_s) begin
            addr_d      = '0;
            rd_ptr_d    = ~rd_ptr_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (handshake_s) begin
            addr_d = addr_q + AW'(1);
        end else begin
            addr_d = addr_q;
        end

        // A capture and a frame retirement on the same edge cancel out
        case ({capture_s, last_hs_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        case (state_q)
            ST_IDLE:   state_d = (occ_d != OCC_EMPTY) ? ST_STREAM : ST_IDLE;
            ST_STREAM: state_d = (last_hs_s && (occ_d == OCC_EMPTY)) ? ST_IDLE : ST_STREAM;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Beat selection from the slot being drained; blanked when not streaming
    always_comb begin
        rd_slot_s = rd_ptr_q ? slot1_q : slot0_q;
        for (int b = 0; b < BEATS; b++) begin
            beats_s[b] = rd_slot_s[b*LW +: LW];
        end
        if (lane_valid) begin
            lane_data = beats_s[addr_q];
            lane_last = (addr_q == LAST_BEAT);
        end else begin
            lane_data = '0;
            lane_last = 1'b0;
        end
        lane_addr     = addr_q;
        frame_cnt     = frame_cnt_q;
        overflow_flag = ovf_q;
    end

    // Control state register
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= OCC_EMPTY;
            addr_q      <= '0;
            frame_cnt_q <= 16'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            addr_q      <= addr_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // Frame storage; contents are hidden by the FSM after reset so no clear
    always_ff @(posedge sys_clk) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

endmodule

// File: tb/tb_channel_msg_streamer.sv
// Randomised and directed bench comparing channel_msg_streamer against a
// queue-of-frames reference model every cycle.
module tb_channel_msg_streamer;

    localparam int N     = 204;
    localparam int Q     = 4;
    localparam int L     = 17;
    localparam int BEATS = 12;
    localparam int AW    = 4;
    localparam int W     = N * Q;
    localparam int LW    = L * Q;

    logic          sys_clk = 1'b0;
    logic          rstn;
    logic [W-1:0]  coded_block;
    logic          tvalid_in;
    logic          ready_out;
    logic [LW-1:0] lane_data;
    logic          lane_valid;
    logic          lane_ready;
    logic [AW-1:0] lane_addr;
    logic          lane_last;
    logic [15:0]   frame_cnt;
    logic          overflow_flag;

    channel_msg_streamer #(.N(N), .QUAN_SIZE(Q), .LANE_NUM(L)) dut (
        .sys_clk      (sys_clk),
        .rstn         (rstn),
        .coded_block  (coded_block),
        .tvalid_in    (tvalid_in),
        .ready_out    (ready_out),
        .lane_data    (lane_data),
        .lane_valid   (lane_valid),
        .lane_ready   (lane_ready),
        .lane_addr    (lane_addr),
        .lane_last    (lane_last),
        .frame_cnt    (frame_cnt),
        .overflow_flag(overflow_flag)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: FIFO of whole frames, current beat, counters
    logic [W-1:0] mq[$];
    int           mbeat;
    logic [15:0]  mcnt;
    logic         movf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with what the model says they must be
    task automatic compare_all();
        logic [W-1:0] f;
        chk("ready_out", LW'(ready_out), LW'(mq.size() < 2));
        chk("lane_valid", LW'(lane_valid), LW'(mq.size() != 0));
        chk("frame_cnt", LW'(frame_cnt), LW'(mcnt));
        chk("overflow_flag", LW'(overflow_flag), LW'(movf));
        chk("lane_addr", LW'(lane_addr), LW'(mbeat));
        if (mq.size() != 0) begin
            f = mq[0];
            chk("lane_data", lane_data, f[mbeat*LW +: LW]);
            chk("lane_last", LW'(lane_last), LW'(mbeat == BEATS - 1));
        end else begin
            chk("lane_data_idle", lane_data, '0);
            chk("lane_last_idle", LW'(lane_last), '0);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge
    task automatic cycle(input logic tv, input logic [W-1:0] blk, input logic lr);
        logic full, hs;
        tvalid_in   = tv;
        coded_block = blk;
        lane_ready  = lr;
        full = (mq.size() == 2);
        hs   = (mq.size() != 0) && lr;
        @(posedge sys_clk);
        if (hs) begin
            if (mbeat == BEATS - 1) begin
                void'(mq.pop_front());
                mbeat = 0;
                mcnt  = mcnt + 16'd1;
            end else begin
                mbeat++;
            end
        end
        if (tv) begin
            if (full) movf = 1'b1;
            else      mq.push_back(blk);
        end
        @(negedge sys_clk);
        compare_all();
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        tvalid_in   = 1'b0;
        lane_ready  = 1'b0;
        coded_block = '0;
        mq.delete();
        mbeat = 0;
        mcnt  = 16'd0;
        movf  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            compare_all();
        end
        rstn = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_block();
        logic [W-1:0] b;
        for (int i = 0; i < W; i += 32) b[i +: 32] = $urandom;
        return b;
    endfunction

    task automatic drain(input int bound, input int ready_pct);
        int n = 0;
        while (mq.size() != 0 && n < bound) begin
            cycle(1'b0, '0, ($urandom_range(99) < ready_pct));
            n++;
        end
        chk("drain_timeout", LW'(mq.size()), '0);
    endtask

    initial begin
        logic [W-1:0]  a, b, c;
        logic [LW-1:0] exp_beat;
        @(negedge sys_clk);

        // Reset values
        do_reset();
        chk("rst_ready_lit", LW'(ready_out), LW'(1));
        chk("rst_data_lit", lane_data, '0);

        // Single ramp frame with literal per-lane values
        for (int s = 0; s < N; s++) a[s*Q +: Q] = Q'(s % 16);
        cycle(1'b1, a, 1'b1);
        for (int k = 0; k < BEATS; k++) begin
            for (int j = 0; j < L; j++) exp_beat[j*Q +: Q] = Q'((17 * k + j) % 16);
            chk("ramp_beat_lit", lane_data, exp_beat);
            chk("ramp_addr_lit", LW'(lane_addr), LW'(k));
            chk("ramp_last_lit", LW'(lane_last), LW'(k == 11));
            cycle(1'b0, '0, 1'b1);
        end
        chk("ramp_cnt_lit", LW'(frame_cnt), LW'(1));
        chk("ramp_idle_lit", LW'(lane_valid), LW'(0));

        // Backpressure at 50%
        cycle(1'b1, rand_block(), 1'b0);
        drain(400, 50);

        // Overflow: A, B buffered, C dropped
        do_reset();
        @(negedge sys_clk);
        a = rand_block(); b = rand_block(); c = rand_block();
        cycle(1'b1, a, 1'b0);
        cycle(1'b1, b, 1'b0);
        chk("ovf_ready_lit", LW'(ready_out), LW'(0));
        cycle(1'b1, c, 1'b0);
        chk("ovf_flag_lit", LW'(overflow_flag), LW'(1));
        chk("ovf_first_lit", lane_data, a[0 +: LW]);
        drain(100, 100);
        chk("ovf_cnt_lit", LW'(frame_cnt), LW'(2));

        // Capture on the same edge as the last-beat handshake
        do_reset();
        @(negedge sys_clk);
        a = rand_block(); b = rand_block();
        cycle(1'b1, a, 1'b1);
        for (int i = 0; i < 11; i++) cycle(1'b0, '0, 1'b1);
        chk("sim_last_lit", LW'(lane_last), LW'(1));
        cycle(1'b1, b, 1'b1);
        chk("sim_valid_lit", LW'(lane_valid), LW'(1));
        chk("sim_addr_lit", LW'(lane_addr), LW'(0));
        chk("sim_data_lit", lane_data, b[0 +: LW]);
        chk("sim_ready_lit", LW'(ready_out), LW'(1));
        drain(100, 100);

        // Reset in the middle of a frame
        a = rand_block(); b = rand_block();
        cycle(1'b1, a, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
        chk("mid_addr_lit", LW'(lane_addr), LW'(5));
        do_reset();
        @(negedge sys_clk);
        cycle(1'b1, b, 1'b1);
        chk("mid_restart_addr_lit", LW'(lane_addr), LW'(0));
        chk("mid_restart_data_lit", lane_data, b[0 +: LW]);
        drain(100, 100);
        chk("mid_cnt_lit", LW'(frame_cnt), LW'(1));

        // Random soak
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(7) == 0), rand_block(), ($urandom_range(99) < 70));
        end
        drain(400, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
